// File: rtl/l2_llc_stub_responder.sv
// Memory-side stand-in for the LLC: answers L2 requests after a fixed delay and keeps
// a small direct-mapped line store so that data written by the L2 can be read back.
module l2_llc_stub_responder #(
    parameter int DEPTH          = 16,
    parameter int LATENCY        = 4,
    parameter int ADDR_W         = 28,
    parameter int WORDS_PER_LINE = 4,
    parameter int BITS_PER_WORD  = 32,
    parameter int MSG_W          = 5,
    parameter int INVACK_W       = 4
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    l2_req_out_valid,
    output logic                                    l2_req_out_ready,
    input  logic [MSG_W-1:0]                        l2_req_out_data_coh_msg,
    input  logic [1:0]                              l2_req_out_data_hprot,
    input  logic [ADDR_W-1:0]                       l2_req_out_data_addr,
    input  logic [WORDS_PER_LINE*BITS_PER_WORD-1:0] l2_req_out_data_line,
    input  logic [WORDS_PER_LINE-1:0]               l2_req_out_data_word_mask,
    output logic                                    l2_rsp_in_valid,
    input  logic                                    l2_rsp_in_ready,
    output logic [MSG_W-1:0]                        l2_rsp_in_data_coh_msg,
    output logic [ADDR_W-1:0]                       l2_rsp_in_data_addr,
    output logic [WORDS_PER_LINE*BITS_PER_WORD-1:0] l2_rsp_in_data_line,
    output logic [WORDS_PER_LINE-1:0]               l2_rsp_in_data_word_mask,
    output logic [INVACK_W-1:0]                     l2_rsp_in_data_invack_cnt,
    output logic                                    bad_req
);

    localparam int LINE_W = WORDS_PER_LINE * BITS_PER_WORD;
    localparam int IDX_W  = $clog2(DEPTH);

    // Opcode encodings mirror the spandex coherence constants.
    localparam logic [MSG_W-1:0] REQ_V      = 5'd0;
    localparam logic [MSG_W-1:0] REQ_S      = 5'd1;
    localparam logic [MSG_W-1:0] REQ_O      = 5'd2;
    localparam logic [MSG_W-1:0] REQ_ODATA  = 5'd3;
    localparam logic [MSG_W-1:0] REQ_WT     = 5'd4;
    localparam logic [MSG_W-1:0] REQ_WB     = 5'd5;
    localparam logic [MSG_W-1:0] RSP_S      = 5'd0;
    localparam logic [MSG_W-1:0] RSP_ODATA  = 5'd1;
    localparam logic [MSG_W-1:0] RSP_O      = 5'd2;
    localparam logic [MSG_W-1:0] RSP_V      = 5'd3;
    localparam logic [MSG_W-1:0] RSP_WB_ACK = 5'd4;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t              state;
    state_t              next_state;
    logic [7:0]          cnt;
    logic [MSG_W-1:0]    req_msg;
    logic [ADDR_W-1:0]   req_addr;
    logic [LINE_W-1:0]   req_line;
    logic [WORDS_PER_LINE-1:0] req_mask;
    logic [LINE_W-1:0]   store [DEPTH];
    logic [LINE_W-1:0]   merged_line;
    logic [MSG_W-1:0]    rsp_msg_next;
    logic [LINE_W-1:0]   rsp_line_next;
    logic                supported;
    logic                is_write;
    logic                accept;
    logic                wait_done;
    logic                rsp_fire;
    logic [IDX_W-1:0]    idx;
    logic                unused_hprot;

    assign unused_hprot = ^l2_req_out_data_hprot;
    assign idx          = req_addr[IDX_W-1:0];
    assign accept       = l2_req_out_valid && l2_req_out_ready;
    assign wait_done    = (state == WAIT) && (cnt == 8'd0);
    assign rsp_fire     = l2_rsp_in_valid && l2_rsp_in_ready;
    assign is_write     = (req_msg == REQ_WT) || (req_msg == REQ_WB);

    always_comb begin
        supported = 1'b0;
        case (l2_req_out_data_coh_msg)
            REQ_V, REQ_S, REQ_O, REQ_ODATA, REQ_WT, REQ_WB: supported = 1'b1;
            default: supported = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept && supported) next_state = WAIT;
            WAIT:    if (cnt == 8'd0)         next_state = RESP;
            RESP:    if (l2_rsp_in_ready)     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        l2_req_out_ready = (state == IDLE);
        l2_rsp_in_valid  = (state == RESP);
    end

    // Masked merge of the latched request into the currently stored line.
    always_comb begin
        merged_line = store[idx];
        for (int i = 0; i < WORDS_PER_LINE; i++) begin
            if (req_mask[i])
                merged_line[i*BITS_PER_WORD +: BITS_PER_WORD] = req_line[i*BITS_PER_WORD +: BITS_PER_WORD];
        end
    end

    always_comb begin
        rsp_msg_next  = RSP_O;
        rsp_line_next = '0;
        case (req_msg)
            REQ_V:     begin rsp_msg_next = RSP_V;      rsp_line_next = store[idx]; end
            REQ_S:     begin rsp_msg_next = RSP_S;      rsp_line_next = store[idx]; end
            REQ_ODATA: begin rsp_msg_next = RSP_ODATA;  rsp_line_next = store[idx]; end
            REQ_O:     rsp_msg_next = RSP_O;
            REQ_WT:    rsp_msg_next = RSP_O;
            REQ_WB:    rsp_msg_next = RSP_WB_ACK;
            default:   rsp_msg_next = RSP_O;
        endcase
    end

    // Request latch, delay counter, store update and registered response fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt                       <= '0;
            req_msg                   <= '0;
            req_addr                  <= '0;
            req_line                  <= '0;
            req_mask                  <= '0;
            bad_req                   <= 1'b0;
            l2_rsp_in_data_coh_msg    <= '0;
            l2_rsp_in_data_addr       <= '0;
            l2_rsp_in_data_line       <= '0;
            l2_rsp_in_data_word_mask  <= '0;
            l2_rsp_in_data_invack_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) store[i] <= '0;
        end else begin
            if (accept && supported) begin
                req_msg  <= l2_req_out_data_coh_msg;
                req_addr <= l2_req_out_data_addr;
                req_line <= l2_req_out_data_line;
                req_mask <= l2_req_out_data_word_mask;
                cnt      <= 8'(LATENCY - 1);
            end
            if (accept && !supported)
                bad_req <= 1'b1;
            if ((state == WAIT) && (cnt != 8'd0))
                cnt <= cnt - 8'd1;
            if (wait_done) begin
                l2_rsp_in_data_coh_msg   <= rsp_msg_next;
                l2_rsp_in_data_addr      <= req_addr;
                l2_rsp_in_data_line      <= rsp_line_next;
                l2_rsp_in_data_word_mask <= req_mask;
                if (is_write) store[idx] <= merged_line;
            end
            if (rsp_fire) begin
                l2_rsp_in_data_coh_msg   <= '0;
                l2_rsp_in_data_addr      <= '0;
                l2_rsp_in_data_line      <= '0;
                l2_rsp_in_data_word_mask <= '0;
            end
        end
    end

endmodule

// File: tb/tb_l2_llc_stub_responder.sv
// Scoreboard bench for the LLC stub responder: directed scenarios plus random traffic
// checked against a word-level memory model.
module tb_l2_llc_stub_responder;

    localparam int DEPTH   = 16;
    localparam int LATENCY = 4;

    localparam logic [4:0] REQ_V = 5'd0, REQ_S = 5'd1, REQ_O = 5'd2, REQ_ODATA = 5'd3;
    localparam logic [4:0] REQ_WT = 5'd4, REQ_WB = 5'd5;
    localparam logic [4:0] RSP_S = 5'd0, RSP_ODATA = 5'd1, RSP_O = 5'd2, RSP_V = 5'd3, RSP_WB_ACK = 5'd4;

    typedef struct packed {
        logic [4:0]   msg;
        logic [27:0]  addr;
        logic [127:0] line;
        logic [3:0]   mask;
        int           accept_cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [4:0]   req_msg = '0;
    logic [1:0]   req_hprot = '0;
    logic [27:0]  req_addr = '0;
    logic [127:0] req_line = '0;
    logic [3:0]   req_mask = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [4:0]   rsp_msg;
    logic [27:0]  rsp_addr;
    logic [127:0] rsp_line;
    logic [3:0]   rsp_mask;
    logic [3:0]   rsp_invack;
    logic         bad_req;

    int     n_checks = 0;
    int     n_fail   = 0;
    int     cyc      = 0;
    bit     hold     = 1'b0;
    bit     mon_en   = 1'b0;
    bit     in_resp  = 1'b0;
    bit     exp_bad  = 1'b0;
    exp_t   sb[$];
    logic [31:0] mem [DEPTH][4];

    l2_llc_stub_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk                       (clk),
        .rst                       (rst),
        .l2_req_out_valid          (req_valid),
        .l2_req_out_ready          (req_ready),
        .l2_req_out_data_coh_msg   (req_msg),
        .l2_req_out_data_hprot     (req_hprot),
        .l2_req_out_data_addr      (req_addr),
        .l2_req_out_data_line      (req_line),
        .l2_req_out_data_word_mask (req_mask),
        .l2_rsp_in_valid           (rsp_valid),
        .l2_rsp_in_ready           (rsp_ready),
        .l2_rsp_in_data_coh_msg    (rsp_msg),
        .l2_rsp_in_data_addr       (rsp_addr),
        .l2_rsp_in_data_line       (rsp_line),
        .l2_rsp_in_data_word_mask  (rsp_mask),
        .l2_rsp_in_data_invack_cnt (rsp_invack),
        .bad_req                   (bad_req)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic modelClear();
        for (int i = 0; i < DEPTH; i++)
            for (int w = 0; w < 4; w++) mem[i][w] = 32'h0;
    endtask

    function automatic logic [127:0] modelLine(input int idx);
        logic [127:0] l;
        for (int w = 0; w < 4; w++) l[w*32 +: 32] = mem[idx][w];
        return l;
    endfunction

    task automatic applyStimulus(input logic [4:0] msg, input logic [27:0] addr,
                                 input logic [127:0] line, input logic [3:0] mask);
        exp_t e;
        int   waited = 0;
        int   idx;
        @(negedge clk);
        while (!req_ready && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL req_ready_timeout: got 0 expected 1");
            return;
        end
        req_valid = 1'b1;
        req_msg   = msg;
        req_addr  = addr;
        req_line  = line;
        req_mask  = mask;
        req_hprot = 2'($urandom);
        e.accept_cyc = cyc + 1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        idx = int'(addr % DEPTH);
        e.addr = addr;
        e.mask = mask;
        e.line = '0;
        case (msg)
            REQ_V:     begin e.msg = RSP_V;     e.line = modelLine(idx); end
            REQ_S:     begin e.msg = RSP_S;     e.line = modelLine(idx); end
            REQ_ODATA: begin e.msg = RSP_ODATA; e.line = modelLine(idx); end
            REQ_O:     e.msg = RSP_O;
            REQ_WT:    e.msg = RSP_O;
            REQ_WB:    e.msg = RSP_WB_ACK;
            default:   e.msg = 5'h1f;
        endcase
        if (msg == REQ_WT || msg == REQ_WB)
            for (int w = 0; w < 4; w++)
                if (mask[w]) mem[idx][w] = line[w*32 +: 32];
        if (msg <= REQ_WB) sb.push_back(e);
        else exp_bad = 1'b1;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitDrain();
        int waited = 0;
        while (sb.size() != 0 && waited < 5000) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("drain_queue_empty", 128'(sb.size()), 128'd0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            rsp_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: compares every presented response against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst || !mon_en) begin
                in_resp = 1'b0;
            end else begin
                checkOutput("bad_req", 128'(bad_req), 128'(exp_bad));
                if (rsp_valid) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("[TB] FAIL unexpected_rsp: got valid msg %h addr %h expected no response", rsp_msg, rsp_addr);
                    end else begin
                        e = sb[0];
                        if (!in_resp) begin
                            checkOutput("latency", 128'(cyc - e.accept_cyc), 128'(LATENCY));
                            in_resp = 1'b1;
                        end
                        checkOutput("rsp_msg", 128'(rsp_msg), 128'(e.msg));
                        checkOutput("rsp_addr", 128'(rsp_addr), 128'(e.addr));
                        checkOutput("rsp_line", rsp_line, e.line);
                        checkOutput("rsp_mask", 128'(rsp_mask), 128'(e.mask));
                        checkOutput("rsp_invack", 128'(rsp_invack), 128'd0);
                        checkOutput("req_ready_in_resp", 128'(req_ready), 128'd0);
                        if (rsp_ready) begin
                            void'(sb.pop_front());
                            in_resp = 1'b0;
                        end
                    end
                end
            end
        end
    end

    initial begin
        int waited;
        logic [4:0] op;
        int r;
        modelClear();
        waitCycles(2);
        checkOutput("reset_req_ready", 128'(req_ready), 128'd1);
        checkOutput("reset_rsp_valid", 128'(rsp_valid), 128'd0);
        checkOutput("reset_rsp_line", rsp_line, 128'd0);
        checkOutput("reset_rsp_msg", 128'({rsp_msg, rsp_addr, rsp_mask, rsp_invack}), 128'd0);
        checkOutput("reset_bad_req", 128'(bad_req), 128'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        mon_en = 1'b1;

        $display("[TB] directed read/write sequence");
        applyStimulus(REQ_V, 28'h3, 128'h0, 4'hF);
        applyStimulus(REQ_WB, 28'h5, {32'h4444_4444, 32'h3333_3333, 32'hBBBB_0002, 32'hAAAA_0001}, 4'h3);
        applyStimulus(REQ_V, 28'h5, 128'h0, 4'hF);
        applyStimulus(REQ_WT, 28'h5, {32'h7777_7777, 32'hCCCC_0003, 32'h5555_5555, 32'h6666_6666}, 4'h4);
        applyStimulus(REQ_ODATA, 28'h5, 128'h0, 4'hF);
        applyStimulus(REQ_O, 28'h5, 128'h0, 4'h1);
        waitDrain();

        $display("[TB] backpressure hold");
        hold = 1'b1;
        applyStimulus(REQ_S, 28'h15, 128'h0, 4'h6);
        waited = 0;
        while (!rsp_valid && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("hold_rsp_seen", 128'(rsp_valid), 128'd1);
        waitCycles(10);
        checkOutput("hold_still_valid", 128'(rsp_valid), 128'd1);
        hold = 1'b0;
        waitDrain();

        $display("[TB] unsupported opcode");
        applyStimulus(5'd9, 28'h2, 128'h0, 4'hF);
        waitCycles(LATENCY + 4);
        checkOutput("bad_req_sticky", 128'(bad_req), 128'd1);
        applyStimulus(REQ_S, 28'h5, 128'h0, 4'hF);
        waitDrain();

        $display("[TB] random traffic");
        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 19);
            op = (r < 18) ? 5'(r % 6) : 5'($urandom_range(6, 31));
            applyStimulus(op, ($urandom_range(0, 1) != 0) ? 28'($urandom_range(0, 40)) : 28'($urandom),
                          {$urandom, $urandom, $urandom, $urandom}, 4'($urandom));
        end
        waitDrain();

        $display("[TB] reset during wait");
        applyStimulus(REQ_WB, 28'h7, {4{32'hDEAD_BEEF}}, 4'hF);
        @(posedge clk);
        #2 rst = 1'b1;
        sb.delete();
        modelClear();
        exp_bad = 1'b0;
        @(negedge clk);
        checkOutput("midrst_rsp_valid", 128'(rsp_valid), 128'd0);
        checkOutput("midrst_req_ready", 128'(req_ready), 128'd1);
        checkOutput("midrst_bad_req", 128'(bad_req), 128'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        waitCycles(LATENCY + 4);
        applyStimulus(REQ_V, 28'h7, 128'h0, 4'hF);
        applyStimulus(REQ_S, 28'h5, 128'h0, 4'hF);
        waitDrain();

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
